// File: rtl/seg7_seconds_monitor.sv
// Receive-side checker for the seven-segment seconds display: synchronises,
// debounces and decodes the segment bus, then checks digit sequence and timing.
module seg7_seconds_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       seg_in,
    input  logic             clear,
    output logic [3:0]       digit,
    output logic             digit_stb,
    output logic             blank,
    output logic             step_err,
    output logic             pattern_err,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       tick_count
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

    logic [6:0]       sync1, sync2, cand, accepted;
    logic [SW-1:0]    stab_cnt;
    logic [CNT_W-1:0] cyc;
    logic             have_prev;

    logic       match, stable, accept;
    logic [4:0] dec;
    logic       dec_valid, is_blank;
    logic [3:0] dec_digit, exp_digit;
    logic       in_seq, step_bad, bad_pat, err_event;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = 5'd0;
        endcase
    endfunction

    // stab_cnt holds matches beyond the reload sample, so the sample arriving
    // this cycle completes a run of STABLE_CYCLES when stab_cnt+2 reaches it.
    always_comb begin
        match     = (sync2 == cand);
        stable    = match ? ((32'(stab_cnt) + 32'd2) >= STABLE_CYCLES)
                          : (STABLE_CYCLES == 32'd1);
        accept    = ena && stable && (sync2 != accepted);
        dec       = decode(sync2);
        dec_valid = dec[4];
        dec_digit = dec[3:0];
        is_blank  = (sync2 == 7'h00);
        exp_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        in_seq    = accept && dec_valid && have_prev && (dec_digit == exp_digit);
        step_bad  = accept && dec_valid && have_prev && (dec_digit != exp_digit);
        bad_pat   = accept && !dec_valid && !is_blank;
        err_event = step_bad || bad_pat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            accepted    <= '0;
            stab_cnt    <= '0;
            cyc         <= '0;
            have_prev   <= 1'b0;
            digit       <= '0;
            digit_stb   <= 1'b0;
            blank       <= 1'b1;
            step_err    <= 1'b0;
            pattern_err <= 1'b0;
            err_count   <= '0;
            period      <= '0;
            tick_count  <= '0;
        end else begin
            sync1     <= seg_in;
            sync2     <= sync1;
            digit_stb <= 1'b0;
            step_err  <= 1'b0;
            if (ena) begin
                if (!match) begin
                    cand     <= sync2;
                    stab_cnt <= '0;
                end else if (32'(stab_cnt) < STABLE_CYCLES) begin
                    stab_cnt <= stab_cnt + SW'(1);
                end

                if (accept && dec_valid)
                    cyc <= '0;
                else if (cyc != '1)
                    cyc <= cyc + CNT_W'(1);

                if (accept) begin
                    accepted <= sync2;
                    if (dec_valid) begin
                        digit     <= dec_digit;
                        blank     <= 1'b0;
                        digit_stb <= 1'b1;
                        have_prev <= 1'b1;
                        if (have_prev) begin
                            step_err <= step_bad;
                            period   <= (cyc == '1) ? cyc : cyc + CNT_W'(1);
                        end
                    end else begin
                        blank     <= is_blank;
                        have_prev <= 1'b0;
                    end
                end

                if (in_seq)
                    tick_count <= tick_count + 8'd1;

                if (bad_pat)
                    pattern_err <= 1'b1;
                else if (clear)
                    pattern_err <= 1'b0;

                if (clear)
                    err_count <= err_event ? 8'd1 : 8'd0;
                else if (err_event && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
